div_issue_queue: RTL and testbench
==================================

Name: div_issue_queue

Overview:
- Request front-end that sits directly upstream of the 8-bit radix-2 divider.
- Buffers tagged division requests in a small FIFO and issues them to the divider one at a time.
- Waits for each divider result, then returns it with its tag over a valid/ready response channel.
- Handles divide-by-zero locally without using the divider, and flags a divider that never answers via a timeout.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- TAG_W, 2, width of the request/response tag.
- TIMEOUT, 32, maximum cycles spent in WAIT before an error response is produced; range 9..255.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept; equals !full.
- req_sign  in  1  1 = signed operands, 0 = unsigned.
- req_dividend  in  8  dividend.
- req_divisor  in  8  divisor.
- req_tag  in  TAG_W  tag returned with the response.
- div_opn_valid  out  1  one-cycle start pulse to the divider.
- div_sign  out  1  operand sign mode to the divider.
- div_dividend  out  8  dividend to the divider.
- div_divisor  out  8  divisor to the divider.
- div_res_valid  in  1  divider result strobe.
- div_result  in  16  divider result; [15:8] = quotient, [7:0] = remainder.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_quotient  out  8  quotient.
- rsp_remainder  out  8  remainder.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_err  out  2  00 = ok, 01 = divide by zero, 10 = timeout.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - FIFO emptied; read/write pointers and count = 0; state = IDLE.
  - All outputs 0, except req_ready = 1.
- Reset mid-operation:
  - Abandons any in-flight divide; queued requests are lost.
  - A div_res_valid arriving after reset is ignored.
- FIFO:
  - Push when req_valid && req_ready; the entry is {sign, dividend, divisor, tag}.
  - req_ready is purely !full. When full, no push occurs even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO not empty, pop the head into the operand/tag registers.
    - If divisor == 0: load rsp_quotient = 8'hFF, rsp_remainder = dividend, rsp_err = 01, go to RESP. No divider pulse is issued.
    - Otherwise go to ISSUE.
  - ISSUE: div_opn_valid = 1 for exactly this one cycle. Clear the timeout counter and go to WAIT.
  - div_sign, div_dividend and div_divisor are registered, driven from the pop cycle onward, and held stable until the next pop.
  - WAIT: increment the timeout counter each cycle.
    - On div_res_valid: capture quotient = div_result[15:8], remainder = div_result[7:0], rsp_err = 00, go to RESP.
    - If the counter reaches TIMEOUT first: quotient = 0, remainder = 0, rsp_err = 10, go to RESP.
    - If div_res_valid arrives in the same cycle the counter reaches TIMEOUT, the result wins.
  - RESP: rsp_valid = 1. Data and tag are held stable until rsp_ready.
    - On rsp_valid && rsp_ready, go to IDLE; rsp_valid is 0 the next cycle.
    - At most one request is in flight.
  - div_res_valid is ignored in IDLE, ISSUE and RESP.
- Latency:
  - Request accepted at edge N into an empty queue and idle FSM: pop at N+1, div_opn_valid high during cycle N+2.
  - Result strobe at edge M: rsp_valid high from M+1.
  - Divide-by-zero: rsp_valid high from N+2.
- Ordering: responses are returned strictly in request order.
- No arithmetic on operands in this block; signed handling is the divider's job.

Test Plan:
- Unsigned 100/7 with tag 1; bench divider model answers with 16'h0E02 after 9 cycles -> rsp_quotient = 14, rsp_remainder = 2, rsp_tag = 1, rsp_err = 00; exactly one div_opn_valid pulse.
- 8'h25/0 with tag 3 -> rsp_quotient = 8'hFF, rsp_remainder = 8'h25, rsp_err = 01, rsp_valid at N+2; div_opn_valid never asserted.
- Divider model stalled, rsp_ready held 0, five back-to-back requests -> first popped, next four fill the FIFO; req_ready drops to 0 after the fifth accepted push.
- A sixth request is held off until the FSM pops; tags are returned 0,1,2,3,0 in order with wrap-around verified.
- Divider model never asserts div_res_valid, TIMEOUT = 32 -> rsp_err = 10 exactly 32 cycles after entering WAIT; a late div_res_valid afterwards is ignored.
- rsp_ready held low 10 cycles during RESP -> rsp fields stable; the next request is not issued until the handshake completes.
- rst asserted during WAIT with 2 entries queued -> next cycle: req_ready = 1, rsp_valid = 0, div_opn_valid = 0, FIFO empty, and no response is produced for the lost requests.

Source files
------------

// File: rtl/div_issue_queue_if.sv
// Bundles the request, divider and response channels of the divide issue queue.
// The queue itself uses the slave modport; its environment uses master.
interface div_issue_queue_if #(
    parameter int TAG_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic             req_sign;
    logic [7:0]       req_dividend;
    logic [7:0]       req_divisor;
    logic [TAG_W-1:0] req_tag;

    logic             div_opn_valid;
    logic             div_sign;
    logic [7:0]       div_dividend;
    logic [7:0]       div_divisor;
    logic             div_res_valid;
    logic [15:0]      div_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_quotient;
    logic [7:0]       rsp_remainder;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;

    modport master (
        output req_valid, req_sign, req_dividend, req_divisor, req_tag,
        input  req_ready,
        input  div_opn_valid, div_sign, div_dividend, div_divisor,
        output div_res_valid, div_result,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_sign, req_dividend, req_divisor, req_tag,
        output req_ready,
        output div_opn_valid, div_sign, div_dividend, div_divisor,
        input  div_res_valid, div_result,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/div_issue_queue.sv
// Front-end for the 8-bit divider: queues tagged requests, issues one at a time,
// answers divide-by-zero locally and reports a divider that never responds.
module div_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2,
    parameter int TIMEOUT = 32
) (
    input logic              clk,
    input logic              rst,
    div_issue_queue_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              sign;
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    state_t            state, state_nxt;
    entry_t            fifo_mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty, push, pop;
    logic              timeout_hit;
    logic [7:0]        tmo_cnt;

    logic              div_sign_r;
    logic [DATA_W-1:0] div_dividend_r, div_divisor_r;
    logic [DATA_W-1:0] rsp_quotient_r, rsp_remainder_r;
    logic [TAG_W-1:0]  rsp_tag_r;
    logic [1:0]        rsp_err_r;

    assign full        = (count == (PTR_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign push        = bus.req_valid && !full;
    assign head        = fifo_mem[rd_ptr];
    assign timeout_hit = ((tmo_cnt + 8'd1) == 8'(TIMEOUT));

    assign bus.req_ready     = !full;
    assign bus.div_opn_valid = (state == ISSUE);
    assign bus.div_sign      = div_sign_r;
    assign bus.div_dividend  = div_dividend_r;
    assign bus.div_divisor   = div_divisor_r;
    assign bus.rsp_valid     = (state == RESP);
    assign bus.rsp_quotient  = rsp_quotient_r;
    assign bus.rsp_remainder = rsp_remainder_r;
    assign bus.rsp_tag       = rsp_tag_r;
    assign bus.rsp_err       = rsp_err_r;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = (head.divisor == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            // A result arriving on the timeout cycle still counts as a result.
            WAIT: begin
                if (bus.div_res_valid || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= entry_t'({bus.req_sign, bus.req_dividend,
                                                bus.req_divisor, bus.req_tag});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tmo_cnt         <= '0;
            div_sign_r      <= 1'b0;
            div_dividend_r  <= '0;
            div_divisor_r   <= '0;
            rsp_quotient_r  <= '0;
            rsp_remainder_r <= '0;
            rsp_tag_r       <= '0;
            rsp_err_r       <= 2'b00;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                div_sign_r     <= head.sign;
                div_dividend_r <= head.dividend;
                div_divisor_r  <= head.divisor;
                rsp_tag_r      <= head.tag;
                if (head.divisor == '0) begin
                    rsp_quotient_r  <= 8'hFF;
                    rsp_remainder_r <= head.dividend;
                    rsp_err_r       <= 2'b01;
                end
            end

            if (state == ISSUE) tmo_cnt <= '0;

            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (bus.div_res_valid) begin
                    rsp_quotient_r  <= bus.div_result[15:8];
                    rsp_remainder_r <= bus.div_result[7:0];
                    rsp_err_r       <= 2'b00;
                end else if (timeout_hit) begin
                    rsp_quotient_r  <= '0;
                    rsp_remainder_r <= '0;
                    rsp_err_r       <= 2'b10;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue with a behavioural divider and a response scoreboard.
module tb_div_issue_queue;
    localparam int TAG_W = 2;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic [1:0] tag;
        logic [1:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int   opn_pulses = 0;
    bit   dm_stall   = 1'b0;
    bit   dm_inject  = 1'b0;
    bit   dm_busy    = 1'b0;
    int   dm_cnt     = 0;
    logic [15:0] dm_res;

    div_issue_queue_if #(.TAG_W(TAG_W)) bus ();

    div_issue_queue #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_div(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa, sd;
        logic [7:0] q, r;
        sa = a;
        sd = b;
        if (s) begin
            q = sa / sd;
            r = sa % sd;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Behavioural divider: answers 9 cycles after each start pulse unless stalled.
    always @(negedge clk) begin
        bus.div_res_valid = 1'b0;
        bus.div_result    = 16'h0000;
        if (rst) begin
            dm_busy = 1'b0;
        end else if (bus.div_opn_valid) begin
            opn_pulses++;
            dm_busy = !dm_stall;
            dm_cnt  = 9;
            dm_res  = ref_div(bus.div_sign, bus.div_dividend, bus.div_divisor);
        end else if (dm_busy) begin
            dm_cnt--;
            if (dm_cnt == 0) begin
                bus.div_res_valid = 1'b1;
                bus.div_result    = dm_res;
                dm_busy           = 1'b0;
            end
        end
        if (dm_inject) begin
            bus.div_res_valid = 1'b1;
            bus.div_result    = 16'h1234;
            dm_inject         = 1'b0;
        end
    end

    // Response monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            chk("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_quotient", bus.rsp_quotient, e.q);
                chk("rsp_remainder", bus.rsp_remainder, e.r);
                chk("rsp_tag", bus.rsp_tag, e.tag);
                chk("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] t, input bit track,
                        input logic [7:0] eq, input logic [7:0] er, input logic [1:0] ee);
        int w;
        w = 0;
        bus.req_valid    = 1'b1;
        bus.req_sign     = s;
        bus.req_dividend = a;
        bus.req_divisor  = b;
        bus.req_tag      = t;
        if (track) sb.push_back('{q: eq, r: er, tag: t, err: ee});
        while (!bus.req_ready && w < 200) begin
            tick(1);
            w++;
        end
        if (w >= 200) chk("push_wait_bound", bus.req_ready, 1);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic pushd(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
        logic [15:0] qr;
        qr = ref_div(s, a, b);
        if (b == 8'd0) push(s, a, b, t, 1'b1, 8'hFF, a, 2'b01);
        else           push(s, a, b, t, 1'b1, qr[15:8], qr[7:0], 2'b00);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) tick(1);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_sign = 1'b0;
        bus.req_dividend = 8'd0;
        bus.req_divisor = 8'd0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_opn_valid", bus.div_opn_valid, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_rsp_quotient", bus.rsp_quotient, 0);
        chk("reset_div_dividend", bus.div_dividend, 0);

        // 100/7 unsigned, tag 1
        bus.rsp_ready = 1'b1;
        push(1'b0, 8'd100, 8'd7, 2'd1, 1'b1, 8'd14, 8'd2, 2'b00);
        chk("t1_no_pulse_yet", bus.div_opn_valid, 0);
        tick(1);
        chk("t1_opn_pulse", bus.div_opn_valid, 1);
        chk("t1_div_dividend", bus.div_dividend, 100);
        chk("t1_div_divisor", bus.div_divisor, 7);
        chk("t1_div_sign", bus.div_sign, 0);
        tick(1);
        chk("t1_pulse_one_cycle", bus.div_opn_valid, 0);
        drain(100);
        chk("t1_pulse_count", opn_pulses, 1);

        // 0x25/0, tag 3: answered locally
        bus.rsp_ready = 1'b0;
        pushd(1'b0, 8'h25, 8'h00, 2'd3);
        chk("dz_not_yet", bus.rsp_valid, 0);
        tick(1);
        chk("dz_rsp_valid", bus.rsp_valid, 1);
        chk("dz_no_pulse", bus.div_opn_valid, 0);
        bus.rsp_ready = 1'b1;
        tick(1);
        chk("dz_valid_drops", bus.rsp_valid, 0);
        chk("dz_pulse_count", opn_pulses, 1);
        chk("dz_drained", sb.size(), 0);

        // Response held for 10 cycles; second request must wait
        bus.rsp_ready = 1'b0;
        pushd(1'b1, 8'hCE, 8'd7, 2'd2);
        pushd(1'b0, 8'd200, 8'd13, 2'd0);
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) tick(1);
        chk("hold_rsp_valid", bus.rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_quotient", bus.rsp_quotient, 8'hF9);
            chk("hold_remainder", bus.rsp_remainder, 8'hFF);
            chk("hold_tag", bus.rsp_tag, 2);
            chk("hold_no_issue", bus.div_opn_valid, 0);
            tick(1);
        end
        chk("hold_pulse_count", opn_pulses, 2);
        bus.rsp_ready = 1'b1;
        drain(100);
        chk("hold_pulse_count_after", opn_pulses, 3);

        // Stalled divider: fill the FIFO, then a sixth request waits for space
        dm_stall = 1'b1;
        bus.rsp_ready = 1'b0;
        push(1'b0, 8'd50, 8'd5, 2'd0, 1'b1, 8'd0, 8'd0, 2'b10);
        pushd(1'b0, 8'd90, 8'd4, 2'd1);
        pushd(1'b0, 8'd33, 8'd8, 2'd2);
        pushd(1'b1, 8'hF0, 8'd3, 2'd3);
        chk("fill_ready_before_full", bus.req_ready, 1);
        pushd(1'b0, 8'd255, 8'd16, 2'd0);
        chk("fill_ready_full", bus.req_ready, 0);
        dm_stall = 1'b0;
        fork
            pushd(1'b0, 8'd77, 8'd5, 2'd1);
            begin
                tick(40);
                chk("fill_still_full", bus.req_ready, 0);
                chk("fill_first_timeout", bus.rsp_err, 2'b10);
                bus.rsp_ready = 1'b1;
            end
        join
        drain(500);
        chk("fill_pulse_count", opn_pulses, 9);

        // Timeout exactly 32 cycles after entering WAIT
        dm_stall = 1'b1;
        bus.rsp_ready = 1'b0;
        push(1'b0, 8'd9, 8'd3, 2'd2, 1'b1, 8'd0, 8'd0, 2'b10);
        tick(2);
        tick(31);
        chk("tmo_not_early", bus.rsp_valid, 0);
        tick(1);
        chk("tmo_rsp_valid", bus.rsp_valid, 1);
        chk("tmo_rsp_err", bus.rsp_err, 2'b10);
        dm_inject = 1'b1;
        tick(2);
        chk("tmo_late_quotient", bus.rsp_quotient, 0);
        chk("tmo_late_err", bus.rsp_err, 2'b10);
        bus.rsp_ready = 1'b1;
        drain(20);
        dm_inject = 1'b1;
        tick(3);
        chk("idle_strobe_ignored", bus.rsp_valid, 0);
        chk("tmo_pulse_count", opn_pulses, 10);

        // Reset during WAIT with two requests queued
        push(1'b0, 8'd10, 8'd2, 2'd0, 1'b0, 8'd0, 8'd0, 2'b00);
        push(1'b0, 8'd20, 8'd3, 2'd1, 1'b0, 8'd0, 8'd0, 2'b00);
        push(1'b0, 8'd30, 8'd4, 2'd2, 1'b0, 8'd0, 8'd0, 2'b00);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_opn_valid", bus.div_opn_valid, 0);
        chk("rst_div_dividend", bus.div_dividend, 0);
        dm_stall = 1'b0;
        dm_inject = 1'b1;
        tick(20);
        chk("rst_no_response", bus.rsp_valid, 0);
        chk("rst_no_issue", opn_pulses, 11);
        pushd(1'b0, 8'd60, 8'd6, 2'd3);
        drain(100);
        chk("rst_fresh_pulse_count", opn_pulses, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
